axi_line_master: RTL and testbench

Parametrised AXI4 master that turns single-word or cache-line CPU requests into AXI4 INCR bursts. It sits between the core's bus request/response interface and the system interconnect. It generalises data width and line size, replies to writes as well as reads, and latches bus errors with their address until acknowledged. It handles one transaction at a time.

---
 rtl/axi_line_master.sv | 270 +++++++++++++++++++++++++++
 tb/tb_axi_line_master.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_line_master.sv
// AXI4 master turning single-word or cache-line CPU requests into INCR bursts, one transaction at a time.
// Optional AXI_TIMEOUT_EN: per-phase stall counter that aborts a hung transaction with an error.
module axi_line_master #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int LINE_BYTES     = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic                      req_line,
    input  logic [DATA_W/8-1:0]       req_strb,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [LINE_BYTES*8-1:0]   req_data,

    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [LINE_BYTES*8-1:0]   resp_data,
    output logic                      resp_err,

    output logic                      err_valid,
    input  logic                      err_ready,
    output logic [ADDR_W-1:0]         err_addr,

    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [ADDR_W-1:0]         m_axi_awaddr,
    output logic [7:0]                m_axi_awlen,
    output logic [2:0]                m_axi_awsize,
    output logic [1:0]                m_axi_awburst,

    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    output logic [DATA_W-1:0]         m_axi_wdata,
    output logic [DATA_W/8-1:0]       m_axi_wstrb,
    output logic                      m_axi_wlast,

    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    input  logic [1:0]                m_axi_bresp,

    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    output logic [ADDR_W-1:0]         m_axi_araddr,
    output logic [7:0]                m_axi_arlen,
    output logic [2:0]                m_axi_arsize,
    output logic [1:0]                m_axi_arburst,

    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready,
    input  logic [DATA_W-1:0]         m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rlast
);

    localparam int BEATS  = LINE_BYTES * 8 / DATA_W;
    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [2:0]        SIZE      = 3'($clog2(STRB_W));
    localparam logic [7:0]        LINE_LEN  = 8'(BEATS - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_BYTES - 1);
    localparam logic [ADDR_W-1:0] WORD_MASK = ADDR_W'(STRB_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_AW,
        S_W,
        S_B,
        S_RSP
    } state_t;

    state_t                          state_q, state_d;
    logic [ADDR_W-1:0]               addr_q, addr_d;
    logic [7:0]                      len_q, len_d;
    logic [7:0]                      cnt_q, cnt_d;
    logic                            line_q, line_d;
    logic [STRB_W-1:0]               strb_q, strb_d;
    logic [BEATS-1:0][DATA_W-1:0]    buf_q, buf_d;
    logic                            err_q, err_d;
    logic                            err_valid_q, err_valid_d;
    logic [ADDR_W-1:0]               err_addr_q, err_addr_d;
    logic [IDX_W-1:0]                slot;

    assign slot = cnt_q[IDX_W-1:0];

`ifdef AXI_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] to_q, to_d;
    logic        busy, hs;

    assign busy = (state_q != S_IDLE) && (state_q != S_RSP);
    assign hs   = (m_axi_arvalid && m_axi_arready) || (m_axi_rready && m_axi_rvalid)
               || (m_axi_awvalid && m_axi_awready) || (m_axi_wvalid && m_axi_wready)
               || (m_axi_bready && m_axi_bvalid);
`endif

    // Held in reset, IDLE must not advertise readiness.
    assign req_ready = rst_n && (state_q == S_IDLE) && !err_valid_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        line_d      = line_q;
        strb_d      = strb_q;
        buf_d       = buf_q;
        err_d       = err_q;
        err_valid_d = err_valid_q;
        err_addr_d  = err_addr_q;
`ifdef AXI_TIMEOUT_EN
        to_d        = '0;
`endif

        if (err_valid_q && err_ready) begin
            err_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    addr_d  = req_line ? (req_addr & ~LINE_MASK) : (req_addr & ~WORD_MASK);
                    len_d   = req_line ? LINE_LEN : 8'd0;
                    line_d  = req_line;
                    strb_d  = req_strb;
                    cnt_d   = 8'd0;
                    err_d   = 1'b0;
                    // Reads start from a zeroed buffer so missing beats read back as zero.
                    buf_d   = req_we ? req_data : '0;
                    state_d = req_we ? S_AW : S_AR;
                end
            end
            S_AR: begin
                if (m_axi_arready) begin
                    state_d = S_R;
                end
            end
            S_R: begin
                if (m_axi_rvalid) begin
                    buf_d[slot] = m_axi_rresp[1] ? '0 : m_axi_rdata;
                    if (m_axi_rresp[1]) begin
                        err_d = 1'b1;
                    end
                    if (cnt_q == len_q) begin
                        state_d = S_RSP;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            S_AW: begin
                if (m_axi_awready) begin
                    state_d = S_W;
                end
            end
            S_W: begin
                if (m_axi_wready) begin
                    if (cnt_q == len_q) begin
                        state_d = S_B;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            S_B: begin
                if (m_axi_bvalid) begin
                    err_d   = err_q | m_axi_bresp[1];
                    state_d = S_RSP;
                end
            end
            S_RSP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                    err_d   = 1'b0;
                    if (err_q) begin
                        err_valid_d = 1'b1;
                        err_addr_d  = addr_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef AXI_TIMEOUT_EN
        // Abort drops every valid/ready at once; the interconnect is expected to be faulty here.
        if (busy) begin
            if (hs) begin
                to_d = '0;
            end else if (to_q == TO_LAST) begin
                state_d = S_RSP;
                err_d   = 1'b1;
            end else begin
                to_d = to_q + 16'd1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            line_q      <= 1'b0;
            strb_q      <= '0;
            buf_q       <= '0;
            err_q       <= 1'b0;
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
`ifdef AXI_TIMEOUT_EN
            to_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            line_q      <= line_d;
            strb_q      <= strb_d;
            buf_q       <= buf_d;
            err_q       <= err_d;
            err_valid_q <= err_valid_d;
            err_addr_q  <= err_addr_d;
`ifdef AXI_TIMEOUT_EN
            to_q        <= to_d;
`endif
        end
    end

    assign resp_valid    = (state_q == S_RSP);
    assign resp_data     = buf_q;
    assign resp_err      = err_q;
    assign err_valid     = err_valid_q;
    assign err_addr      = err_addr_q;

    assign m_axi_arvalid = (state_q == S_AR);
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = len_q;
    assign m_axi_arsize  = SIZE;
    assign m_axi_arburst = 2'b01;
    assign m_axi_rready  = (state_q == S_R);

    assign m_axi_awvalid = (state_q == S_AW);
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = len_q;
    assign m_axi_awsize  = SIZE;
    assign m_axi_awburst = 2'b01;

    assign m_axi_wvalid  = (state_q == S_W);
    assign m_axi_wdata   = buf_q[slot];
    assign m_axi_wstrb   = line_q ? {STRB_W{1'b1}} : strb_q;
    assign m_axi_wlast   = (state_q == S_W) && (cnt_q == len_q);
    assign m_axi_bready  = (state_q == S_B);

    // Beat count, not rlast, ends a read; only the error bit of each response matters.
    logic unused_bits;
`ifdef AXI_TIMEOUT_EN
    assign unused_bits = ^{m_axi_rresp[0], m_axi_bresp[0], m_axi_rlast};
`else
    assign unused_bits = ^{m_axi_rresp[0], m_axi_bresp[0], m_axi_rlast, 32'(TIMEOUT_CYCLES)};
`endif

endmodule

// File: tb/tb_axi_line_master.sv
// Directed bench for axi_line_master: line/single reads and writes, error latching, backpressure, reset, timeout.
module tb_axi_line_master;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LB = 64;
    localparam int LW = LB * 8;
`ifdef AXI_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, req_we, req_line;
    logic [3:0]    req_strb;
    logic [AW-1:0] req_addr;
    logic [LW-1:0] req_data;
    logic          resp_valid, resp_ready, resp_err;
    logic [LW-1:0] resp_data;
    logic          err_valid, err_ready;
    logic [AW-1:0] err_addr;
    logic          awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [AW-1:0] awaddr, araddr;
    logic [7:0]    awlen, arlen;
    logic [2:0]    awsize, arsize;
    logic [1:0]    awburst, arburst, bresp, rresp;
    logic [DW-1:0] wdata, rdata;
    logic [3:0]    wstrb;
    logic          arvalid, arready, rvalid, rready, rlast;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    axi_line_master #(
        .ADDR_W(AW), .DATA_W(DW), .LINE_BYTES(LB), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_line(req_line),
        .req_strb(req_strb), .req_addr(req_addr), .req_data(req_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
        .err_valid(err_valid), .err_ready(err_ready), .err_addr(err_addr),
        .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen),
        .m_axi_awsize(awsize), .m_axi_awburst(awburst),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
        .m_axi_wlast(wlast),
        .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bresp(bresp),
        .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr), .m_axi_arlen(arlen),
        .m_axi_arsize(arsize), .m_axi_arburst(arburst),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
        .m_axi_rlast(rlast)
    );

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered at a negedge with the DUT idle; returns at the negedge after the handshake.
    task automatic send_req(input logic we, input logic line, input logic [3:0] strb,
                            input logic [AW-1:0] addr, input logic [LW-1:0] data);
        check("req_ready_before_req", req_ready, 1);
        req_valid = 1'b1; req_we = we; req_line = line; req_strb = strb;
        req_addr = addr; req_data = data;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic ar_accept();
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
    endtask

    task automatic give_beats(input int n, input logic [DW-1:0] base, input int err_beat);
        for (int k = 0; k < n; k++) begin
            rvalid = 1'b1;
            rdata  = base + DW'(k);
            rresp  = (k == err_beat) ? 2'b10 : 2'b00;
            rlast  = (k == n - 1);
            @(negedge clk);
        end
        rvalid = 1'b0; rresp = 2'b00; rlast = 1'b0;
    endtask

    task automatic accept_resp();
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic pulse_err_ready();
        err_ready = 1'b1;
        @(negedge clk);
        err_ready = 1'b0;
    endtask

    initial begin
        logic [LW-1:0] exp_data;
        logic [LW-1:0] wr_line;
        int            got;
        int            n;

        rst_n = 1'b0;
        req_valid = 0; req_we = 0; req_line = 0; req_strb = 0; req_addr = 0; req_data = '0;
        resp_ready = 0; err_ready = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_arvalid", arvalid, 0);
        check("rst_awvalid", awvalid, 0);
        check("rst_wvalid", wvalid, 0);
        check("rst_bready", bready, 0);
        check("rst_rready", rready, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_err_valid", err_valid, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_err_addr", err_addr, 0);
        check("rst_araddr", araddr, 0);
        check("rst_arlen", arlen, 0);
        check("rst_awaddr", awaddr, 0);
        check("rst_awlen", awlen, 0);

        rst_n = 1'b1;
        @(negedge clk);

        // 1: line read, 16 beats of value k
        send_req(1'b0, 1'b1, 4'h0, 32'h1000_0044, '0);
        check("t1_arvalid", arvalid, 1);
        check("t1_araddr", araddr, 32'h1000_0040);
        check("t1_arlen", arlen, 15);
        check("t1_arsize", arsize, 2);
        check("t1_arburst", arburst, 1);
        check("t1_rready_early", rready, 0);
        ar_accept();
        check("t1_rready", rready, 1);
        check("t1_arvalid_drop", arvalid, 0);
        give_beats(16, 32'h0, -1);
        exp_data = '0;
        for (int k = 0; k < 16; k++) exp_data[k*DW +: DW] = DW'(k);
        check("t1_rready_drop", rready, 0);
        check("t1_resp_valid", resp_valid, 1);
        check("t1_resp_err", resp_err, 0);
        check("t1_resp_data", resp_data, exp_data);
        accept_resp();
        check("t1_resp_valid_clr", resp_valid, 0);

        // 2: single write with partial strobe
        send_req(1'b1, 1'b0, 4'h3, 32'h2000_0006, 512'hDEADBEEF);
        check("t2_awvalid", awvalid, 1);
        check("t2_awaddr", awaddr, 32'h2000_0004);
        check("t2_awlen", awlen, 0);
        check("t2_awsize", awsize, 2);
        check("t2_wvalid_early", wvalid, 0);
        awready = 1'b1; @(negedge clk); awready = 1'b0;
        check("t2_wvalid", wvalid, 1);
        check("t2_wdata", wdata, 32'hDEADBEEF);
        check("t2_wstrb", wstrb, 4'h3);
        check("t2_wlast", wlast, 1);
        wready = 1'b1; @(negedge clk); wready = 1'b0;
        check("t2_wvalid_drop", wvalid, 0);
        check("t2_bready", bready, 1);
        bvalid = 1'b1; bresp = 2'b00; @(negedge clk); bvalid = 1'b0;
        check("t2_resp_valid", resp_valid, 1);
        check("t2_resp_err", resp_err, 0);
        accept_resp();
        check("t2_err_valid", err_valid, 0);

        // 3: read error on beat 5 latches address and blocks new requests
        send_req(1'b0, 1'b1, 4'h0, 32'h3000_0084, '0);
        check("t3_araddr", araddr, 32'h3000_0080);
        ar_accept();
        give_beats(16, 32'h100, 5);
        check("t3_resp_err", resp_err, 1);
        check("t3_slot4", resp_data[4*DW +: DW], 32'h104);
        check("t3_slot5", resp_data[5*DW +: DW], 32'h0);
        check("t3_slot6", resp_data[6*DW +: DW], 32'h106);
        check("t3_err_valid_before", err_valid, 0);
        accept_resp();
        check("t3_err_valid", err_valid, 1);
        check("t3_err_addr", err_addr, 32'h3000_0080);
        check("t3_resp_err_clr", resp_err, 0);
        check("t3_req_ready_blocked", req_ready, 0);
        req_valid = 1'b1; req_we = 1'b0; req_line = 1'b0; req_addr = 32'h0000_0100;
        repeat (3) @(negedge clk);
        check("t3_no_ar_while_err", arvalid, 0);
        check("t3_req_ready_still0", req_ready, 0);
        req_valid = 1'b0;
        pulse_err_ready();
        check("t3_err_valid_clr", err_valid, 0);
        check("t3_req_ready_back", req_ready, 1);

        // 4: line write, awready stalled 7 cycles, wready toggling
        wr_line = '0;
        for (int k = 0; k < 16; k++) wr_line[k*DW +: DW] = 32'hA000_0000 + DW'(k);
        send_req(1'b1, 1'b1, 4'h1, 32'h4000_0010, wr_line);
        check("t4_awaddr", awaddr, 32'h4000_0000);
        check("t4_awlen", awlen, 15);
        for (int c = 0; c < 7; c++) begin
            check("t4_awvalid_hold", awvalid, 1);
            check("t4_wvalid_early", wvalid, 0);
            @(negedge clk);
        end
        awready = 1'b1; @(negedge clk); awready = 1'b0;
        got = 0;
        for (int c = 0; c < 64 && got < 16; c++) begin
            wready = (c % 2 == 0);
            check("t4_wvalid", wvalid, 1);
            if (wready) begin
                check("t4_wdata", wdata, 32'hA000_0000 + DW'(got));
                check("t4_wlast", wlast, (got == 15));
                check("t4_wstrb", wstrb, 4'hF);
                got++;
            end
            @(negedge clk);
        end
        wready = 1'b0;
        check("t4_beats", got, 16);
        check("t4_wvalid_drop", wvalid, 0);
        check("t4_bready", bready, 1);
        bvalid = 1'b1; @(negedge clk); bvalid = 1'b0;
        check("t4_resp_valid", resp_valid, 1);
        check("t4_resp_err", resp_err, 0);
        accept_resp();

        // 5: reset on beat 8 of a read, then a fresh single read
        send_req(1'b0, 1'b1, 4'h0, 32'h5000_0100, '0);
        ar_accept();
        give_beats(8, 32'h200, -1);
        rvalid = 1'b1; rdata = 32'h208; rst_n = 1'b0;
        @(negedge clk);
        rvalid = 1'b0;
        check("t5_rready", rready, 0);
        check("t5_resp_valid", resp_valid, 0);
        check("t5_arvalid", arvalid, 0);
        check("t5_resp_data", resp_data, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_idle", req_ready, 1);
        send_req(1'b0, 1'b0, 4'h0, 32'h5000_000B, '0);
        check("t5_araddr", araddr, 32'h5000_0008);
        check("t5_arlen", arlen, 0);
        ar_accept();
        give_beats(1, 32'h1234_5678, -1);
        check("t5_resp_valid2", resp_valid, 1);
        check("t5_resp_err2", resp_err, 0);
        check("t5_resp_data2", resp_data, 512'h12345678);
        accept_resp();

`ifdef AXI_TIMEOUT_EN
        // 6: arready never comes; abort after TO stalled cycles
        send_req(1'b0, 1'b1, 4'h0, 32'h6000_0000, '0);
        n = 0;
        for (int c = 0; c < 40; c++) begin
            if (!arvalid) break;
            n++;
            @(negedge clk);
        end
        check("t6_ar_cycles", n, 16);
        check("t6_resp_valid", resp_valid, 1);
        check("t6_resp_err", resp_err, 1);
        check("t6_rready", rready, 0);
        accept_resp();
        check("t6_err_valid", err_valid, 1);
        check("t6_err_addr", err_addr, 32'h6000_0000);
        pulse_err_ready();
        check("t6_err_valid_clr", err_valid, 0);
`else
        n = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
